// File: rtl/fp_mul_seq.sv
// Sequential FP32 multiplier: shift-and-add mantissa product over MANT_W cycles,
// exponent add with bias correction, truncating normalization, valid/ready on both sides.
module fp_mul_seq #(
  parameter int BIAS   = 127,
  parameter int MANT_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflag,
  output logic        underflag
);

  localparam int CW = $clog2(MANT_W);
  localparam int PW = 2 * MANT_W;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t              state_reg, state_next;
  logic [PW-1:0]       acc_reg, acc_next;
  logic [MANT_W-1:0]   mcand_reg, mcand_next;
  logic [MANT_W-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic signed [9:0]   exp_reg, exp_next;
  logic                sign_reg, sign_next;
  logic [31:0]         result_reg, result_next;
  logic                over_reg, over_next;
  logic                under_reg, under_next;

  // Per-operand field decode; denormals count as zero.
  logic [31:0] ops      [2];
  logic [7:0]  op_exp   [2];
  logic [22:0] op_frac  [2];
  logic        op_nan   [2];
  logic        op_inf   [2];
  logic        op_zero  [2];

  assign ops[0] = A;
  assign ops[1] = B;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      assign op_exp[gi]  = ops[gi][30:23];
      assign op_frac[gi] = ops[gi][22:0];
      assign op_nan[gi]  = (op_exp[gi] == 8'hFF) && (op_frac[gi] != 23'h0);
      assign op_inf[gi]  = (op_exp[gi] == 8'hFF) && (op_frac[gi] == 23'h0);
      assign op_zero[gi] = (op_exp[gi] == 8'h00);
    end
  endgenerate

  logic               in_sign;
  logic [MANT_W:0]    sum;
  logic signed [9:0]  norm_exp;
  logic [22:0]        norm_frac;

  assign in_sign = A[31] ^ B[31];

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    exp_next    = exp_reg;
    sign_next   = sign_reg;
    result_next = result_reg;
    over_next   = over_reg;
    under_next  = under_reg;

    sum = {1'b0, acc_reg[PW-1:MANT_W]} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);

    if (acc_reg[PW-1]) begin
      norm_frac = acc_reg[PW-2 -: 23];
      norm_exp  = exp_reg + 10'sd1;
    end else begin
      norm_frac = acc_reg[PW-3 -: 23];
      norm_exp  = exp_reg;
    end

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next = in_sign;
          if (op_nan[0] || op_nan[1] ||
              (op_inf[0] && op_zero[1]) || (op_zero[0] && op_inf[1])) begin
            result_next = 32'h7FC0_0000;
            over_next   = 1'b0;
            under_next  = 1'b0;
            state_next  = DONE;
          end else if (op_inf[0] || op_inf[1]) begin
            result_next = {in_sign, 8'hFF, 23'h0};
            over_next   = 1'b0;
            under_next  = 1'b0;
            state_next  = DONE;
          end else if (op_zero[0] || op_zero[1]) begin
            result_next = {in_sign, 31'h0};
            over_next   = 1'b0;
            under_next  = 1'b0;
            state_next  = DONE;
          end else begin
            mcand_next  = MANT_W'({1'b1, op_frac[0]});
            mplier_next = MANT_W'({1'b1, op_frac[1]});
            acc_next    = '0;
            cnt_next    = '0;
            // 10-bit two's complement keeps 254+254 and 1+1-BIAS unambiguous.
            exp_next    = 10'({2'b00, op_exp[0]} + {2'b00, op_exp[1]} - 10'(BIAS));
            state_next  = MUL;
          end
        end
      end
      MUL: begin
        acc_next    = {sum, acc_reg[MANT_W-1:1]};
        mplier_next = mplier_reg >> 1;
        if (cnt_reg == CW'(MANT_W - 1)) begin
          cnt_next   = '0;
          state_next = NORM;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      NORM: begin
        over_next  = 1'b0;
        under_next = 1'b0;
        if (norm_exp >= 10'sd255) begin
          result_next = {sign_reg, 8'hFF, 23'h0};
          over_next   = 1'b1;
        end else if (norm_exp <= 10'sd0) begin
          result_next = {sign_reg, 31'h0};
          under_next  = 1'b1;
        end else begin
          result_next = {sign_reg, norm_exp[7:0], norm_frac};
        end
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      exp_reg    <= '0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
      over_reg   <= 1'b0;
      under_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
      exp_reg    <= exp_next;
      sign_reg   <= sign_next;
      result_reg <= result_next;
      over_reg   <= over_next;
      under_reg  <= under_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign overflag  = over_reg;
  assign underflag = under_reg;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: table of operand/result vectors with latency,
// plus backpressure and mid-operation reset sequences.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflag;
  logic        underflag;

  int n_total = 0;
  int n_pass  = 0;

  fp_mul_seq #(.BIAS(127), .MANT_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflag  (overflag),
    .underflag (underflag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ov;
    logic        un;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
  endtask

  // Captures operands, returns the cycle (1 = the cycle right after capture)
  // at which out_valid is first seen high, leaving the result unconsumed.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int cyc);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_issue", {31'h0, in_ready}, 32'd1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] held;
    logic stable;

    vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 26};
    vecs[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 26};
    vecs[2]  = '{32'hBF80_0000, 32'h4080_0000, 32'hC080_0000, 1'b0, 1'b0, 26};
    vecs[3]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0, 26};
    vecs[4]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, 26};
    vecs[5]  = '{32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 1'b1, 26};
    vecs[6]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 26};
    vecs[7]  = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1};
    vecs[8]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0, 1};
    vecs[9]  = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0, 1'b0, 1};
    vecs[10] = '{32'h7FC0_0001, 32'h4000_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1};
    vecs[11] = '{32'h7FC0_0001, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1};
    vecs[12] = '{32'h7F80_0000, 32'h0000_0001, 32'h7FC0_0000, 1'b0, 1'b0, 1};
    vecs[13] = '{32'hC000_0000, 32'hC040_0000, 32'h40C0_0000, 1'b0, 1'b0, 26};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  {31'h0, in_ready},  32'd1);
    chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
    chk("reset_result",    result,             32'd0);
    chk("reset_flags",     {30'h0, overflag, underflag}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].a, vecs[i].b, cyc);
      $display("vec %0d: 0x%08h * 0x%08h -> 0x%08h ov=%0b un=%0b lat=%0d",
               i, vecs[i].a, vecs[i].b, result, overflag, underflag, cyc);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_overflag", i), {31'h0, overflag}, {31'h0, vecs[i].ov});
      chk($sformatf("v%0d_underflag", i), {31'h0, underflag}, {31'h0, vecs[i].un});
      consume();
      chk($sformatf("v%0d_in_ready_after", i), {31'h0, in_ready}, 32'd1);
    end

    // Backpressure: stalled result must hold while stray operands are offered.
    issue(32'h4000_0000, 32'h4040_0000, cyc);
    chk("bp_latency", cyc, 26);
    held = result;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      A = 32'h7FC0_0001; B = 32'h0000_0000; in_valid = (k % 2 == 0);
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== 32'h40C0_0000 || overflag || underflag)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    $display("backpressure: held 0x%08h, stable=%0b", held, stable);
    chk("bp_result", held, 32'h40C0_0000);
    chk("bp_stable", {31'h0, stable}, 32'd1);
    consume();
    chk("bp_in_ready_after", {31'h0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'h0, out_valid}, 32'd0);
    chk("bp_result_kept", result, 32'h40C0_0000);

    // Reset at MUL count 10 aborts the operation.
    A = 32'h3FC0_0000; B = 32'h3FC0_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("mid-op reset: out_valid=%0b result=0x%08h in_ready=%0b", out_valid, result, in_ready);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_late_result", {31'h0, out_valid}, 32'd0);
    issue(32'h4000_0000, 32'h4040_0000, cyc);
    $display("post-reset: result=0x%08h lat=%0d", result, cyc);
    chk("post_rst_latency", cyc, 26);
    chk("post_rst_result",  result, 32'h40C0_0000);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Multi-cycle IEEE-754 single-precision multiplier; the inverse operation to the combinational FP divider in the same ALU.
- Multiplies the 24-bit mantissas by iterative shift-and-add instead of a combinational array.
- Adds exponents with bias correction and normalizes the product.
- Uses a valid/ready handshake on both sides so the ALU sequencer can stall it.

Parameters:
- BIAS, 127, exponent bias subtracted after the exponent add.
- MANT_W, 24, mantissa width including the hidden bit; also the iteration count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A/B are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  32  operand A, FP32.
- B  input  32  operand B, FP32.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  32  FP32 product.
- overflag  output  1  exponent overflow occurred.
- underflag  output  1  exponent underflow occurred.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset:
  - State goes to IDLE; in_ready=1 after reset.
  - out_valid=0, result=0, overflag=0, underflag=0.
  - Accumulator and counter are cleared.
  - A reset asserted mid-operation aborts the operation; no result is produced.
- States: IDLE, MUL, NORM, DONE.
- IDLE:
  - in_ready=1. Operands are captured on the edge T where in_valid && in_ready.
  - sign = A[31]^B[31]. Mantissa = {1, frac}. ext_exp (10-bit signed) = expA + expB - BIAS.
  - Special case present → go to DONE with the special result, so out_valid=1 at T+1. Otherwise → MUL.
- Special cases, in priority order:
  1. Either input NaN (exp=255, frac≠0) → 0x7FC00000.
  2. Inf × zero, where zero means exp=0 (denormals flush to zero) → 0x7FC00000.
  3. Either input Inf → {sign, 8'hFF, 23'h0}.
  4. Either input zero → {sign, 31'h0}.
  - Flags are 0 for all special cases.
- MUL:
  - 24 cycles, counter 0..23.
  - Each cycle: if multiplier LSB=1, add the multiplicand to the upper half of the 48-bit accumulator (with carry); then shift {carry, acc} right by 1; shift the multiplier right.
  - After count 23 → NORM.
- NORM (1 cycle):
  - If product[47]=1: frac = product[46:24], ext_exp+1. Otherwise frac = product[45:23].
  - Truncate; no rounding.
  - If ext_exp >= 255: result = {sign, 8'hFF, 0}, overflag=1.
  - Else if ext_exp <= 0: result = {sign, 31'h0}, underflag=1.
  - Else: normal result.
  - Then → DONE.
- Latency: normal operands give out_valid at T+26.
- DONE:
  - out_valid=1. result and flags are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE; out_valid=0 the next cycle. result and flags keep their last values.
- Handshake rules:
  - in_valid is ignored outside IDLE. The block does not accept new operands in the cycle the result is consumed; in_ready rises the cycle after.
  - Operand changes after capture have no effect.
- Width rules: exponent math is 10-bit two's complement, so there is no wraparound on 254+254 or 1+1-127.

Test Plan:
- 2.0 (0x40000000) × 3.0 (0x40400000) → result=0x40C00000, flags 0. in_ready low T+1..T+26; out_valid rises exactly at T+26.
- 1.5 × 1.5 (0x3FC00000 × 0x3FC00000) → 0x40100000, which exercises the product[47] normalize path. -1.0 × 4.0 (0xBF800000 × 0x40800000) → 0xC0800000.
- Overflow: 0x7F000000 × 0x7F000000 → 0x7F800000, overflag=1. Underflow: 0x00800000 × 0x00800000 → 0x00000000, underflag=1.
- Specials:
  - 0x00000000 × 0x7F800000 → 0x7FC00000 at T+1.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x80000000 × 0x3F800000 → 0x80000000.
  - 0x7FC00001 × any → 0x7FC00000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result, flags and out_valid stay stable and in_ready stays 0. Pulsing in_valid with new operands during the stall changes nothing. Raise out_ready → in_ready=1 the following cycle.
- Reset mid-MUL: assert rst at count 10 → next cycle out_valid=0, result=0, in_ready=1. A subsequent 2.0 × 3.0 gives 0x40C00000 at the normal latency.
